// File: rtl/hsync_line_gen.sv
// hsync_line_gen -- horizontal line timing generator.
//
// Walks a line through four phases (SYNC, BACK, ACTIVE, FRONT) using one
// phase counter that restarts at 0 on every phase entry. The phase lengths
// are taken from shadow registers so that a line always runs with one
// consistent set of lengths. A length of 0 behaves like 1, so no phase is
// ever skipped.
//
// Ports
//   clock        in   1   rising-edge clock, one pixel per clock
//   reset        in   1   asynchronous active-high reset
//   SynchPulse   in  10   sync phase length (clocks)
//   BackPorch    in  10   back porch length (clocks)
//   ActiveVideo  in  10   active video length (clocks)
//   FrontPorch   in  10   front porch length (clocks)
//   hsync        out  1   low during SYNC, high otherwise
//   LineEnd      out  1   high on the last clock of each line
//   xposition    out 10   pixel column during ACTIVE, else 0
//   ActiveX      out  1   high during ACTIVE
//
// state  | meaning
// -------+------------------------------------------
// SYNC   | horizontal sync pulse, hsync driven low
// BACK   | back porch
// ACTIVE | active video, xposition = counter
// FRONT  | front porch, last clock raises LineEnd

module hsync_line_gen (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] SynchPulse,
  input  logic [9:0] BackPorch,
  input  logic [9:0] ActiveVideo,
  input  logic [9:0] FrontPorch,
  output logic       hsync,
  output logic       LineEnd,
  output logic [9:0] xposition,
  output logic       ActiveX
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [9:0] cnt, cnt_nx;
  logic [9:0] sh_sync, sh_back, sh_active, sh_front;
  logic [9:0] phase_last;
  logic       at_last;
  logic       line_wrap;

  // Terminal count of a phase; a zero length collapses to a single clock.
  function automatic logic [9:0] last_of(input logic [9:0] len);
    return (len == 10'd0) ? 10'd0 : len - 10'd1;
  endfunction

  always_comb begin
    phase_last = last_of(sh_sync);
    case (state)
      SYNC:    phase_last = last_of(sh_sync);
      BACK:    phase_last = last_of(sh_back);
      ACTIVE:  phase_last = last_of(sh_active);
      FRONT:   phase_last = last_of(sh_front);
      default: phase_last = last_of(sh_sync);
    endcase
  end

  assign at_last   = (cnt == phase_last);
  assign line_wrap = (state == FRONT) && at_last;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 10'd1;
    if (at_last) begin
      cnt_nx = 10'd0;
      case (state)
        SYNC:    state_nx = BACK;
        BACK:    state_nx = ACTIVE;
        ACTIVE:  state_nx = FRONT;
        FRONT:   state_nx = SYNC;
        default: state_nx = SYNC;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SYNC;
      cnt   <= 10'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Shadow lengths are loaded on clock edges while reset is held and at the
  // FRONT->SYNC wrap. They need no reset value of their own: the outputs in
  // reset depend only on state, and the first line after release uses the
  // values captured while reset was high.
  always_ff @(posedge clock) begin
    if (reset || line_wrap) begin
      sh_sync   <= SynchPulse;
      sh_back   <= BackPorch;
      sh_active <= ActiveVideo;
      sh_front  <= FrontPorch;
    end
  end

  assign hsync     = (state != SYNC);
  assign ActiveX   = (state == ACTIVE);
  assign xposition = ActiveX ? cnt : 10'd0;
  assign LineEnd   = line_wrap;

endmodule

// File: tb/tb_hsync_line_gen.sv
module tb_hsync_line_gen;

  logic       clock;
  logic       reset;
  logic [9:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch;
  logic       hsync, LineEnd, ActiveX;
  logic [9:0] xposition;

  hsync_line_gen dut (
    .clock       (clock),
    .reset       (reset),
    .SynchPulse  (SynchPulse),
    .BackPorch   (BackPorch),
    .ActiveVideo (ActiveVideo),
    .FrontPorch  (FrontPorch),
    .hsync       (hsync),
    .LineEnd     (LineEnd),
    .xposition   (xposition),
    .ActiveX     (ActiveX)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       hs;
    logic       ax;
    logic [9:0] x;
    logic       le;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;
  int   le_seen = 0;
  int   le_expected = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents one observation per clock while out of reset.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      obs_t got, want;
      got = '{hs: hsync, ax: ActiveX, x: xposition, le: LineEnd};
      if (LineEnd === 1'b1) le_seen++;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("cycle_outputs", 32'(got), 32'(want));
      end
    end
  end

  // Reference: a line is four phases laid end to end, each max(len,1) long.
  function automatic int push_line(input int s, input int b, input int a, input int f);
    int lens[4];
    int total_len;
    lens[0] = (s == 0) ? 1 : s;
    lens[1] = (b == 0) ? 1 : b;
    lens[2] = (a == 0) ? 1 : a;
    lens[3] = (f == 0) ? 1 : f;
    total_len = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        obs_t e;
        e.hs = (p != 0);
        e.ax = (p == 2);
        e.x  = (p == 2) ? 10'(i) : 10'd0;
        e.le = (p == 3) && (i == lens[p] - 1);
        exp_q.push_back(e);
      end
      total_len += lens[p];
    end
    return total_len;
  endfunction

  task automatic set_lens(input int s, input int b, input int a, input int f);
    SynchPulse  = 10'(s);
    BackPorch   = 10'(b);
    ActiveVideo = 10'(a);
    FrontPorch  = 10'(f);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"},     32'(hsync),     32'd0);
    check({tag, "_LineEnd"},   32'(LineEnd),   32'd0);
    check({tag, "_ActiveX"},   32'(ActiveX),   32'd0);
    check({tag, "_xposition"}, 32'(xposition), 32'd0);
  endtask

  // Holds reset over a few edges, then releases it just after a rising edge,
  // so the following period is cycle 0 of the first line.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset_hold");
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Runs one line starting at cycle 0 (called 1 time unit after a rising
  // edge). Optionally changes the inputs in cycle chg_at, or asserts reset
  // in the middle of cycle abort_at.
  task automatic run_line(input int chg_at, input int ns, input int nb, input int na,
                          input int nf, input int abort_at);
    int len;
    len = push_line(int'(SynchPulse), int'(BackPorch), int'(ActiveVideo), int'(FrontPorch));
    for (int c = 0; c < len; c++) begin
      if (c == chg_at) set_lens(ns, nb, na, nf);
      if (c == abort_at) begin
        #1 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        do_reset();
        return;
      end
      @(posedge clock);
      #1;
    end
    le_expected++;
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++) run_line(-1, 0, 0, 0, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_lens(2, 3, 5, 2);
    #1 check_reset_outputs("reset_initial");
    mon_en = 1'b1;
    do_reset();

    // 12-clock line, repeated for 300 clocks.
    run_lines(25);

    // ActiveVideo 5 -> 3 in cycle 6: this line stays 12, next one is 10.
    run_line(6, 2, 3, 3, 2, -1);
    run_lines(2);

    // All lengths zero: 4-clock lines.
    run_line(3, 0, 0, 0, 0, -1);
    run_lines(6);

    // All lengths one.
    run_line(1, 1, 1, 1, 1, -1);
    run_lines(4);

    // Asynchronous reset during ACTIVE (cycle 7), then restart.
    run_line(0, 2, 3, 5, 2, -1);
    run_line(-1, 0, 0, 0, 0, 7);
    run_lines(3);

    // Randomised lengths and mid-line changes.
    for (int i = 0; i < 40; i++) begin
      int len_now;
      len_now = (SynchPulse == 0 ? 1 : int'(SynchPulse)) + (BackPorch == 0 ? 1 : int'(BackPorch))
              + (ActiveVideo == 0 ? 1 : int'(ActiveVideo)) + (FrontPorch == 0 ? 1 : int'(FrontPorch));
      run_line(int'($urandom_range(len_now - 1, 0)),
               int'($urandom_range(12, 0)), int'($urandom_range(12, 0)),
               int'($urandom_range(20, 0)), int'($urandom_range(12, 0)), -1);
    end

    // Random reset abort somewhere in a line.
    run_line(0, 4, 4, 8, 4, -1);
    run_line(-1, 0, 0, 0, 0, int'($urandom_range(19, 1)));
    run_lines(2);

    // 800-clock standard line.
    run_line(0, 96, 48, 640, 16, -1);
    run_lines(2);

    reset = 1'b1;
    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("lineend_count", 32'(le_seen), 32'(le_expected));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsync_line_gen.md
HSYNC_LINE_GEN -- requirements
Module: hsync_line_gen

Interface
REQ-001 The block SHALL have exactly one clock and use an asynchronous, active-high reset.
REQ-002 clock  input  1  Rising-edge clock; one clock equals one pixel period.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 SynchPulse  input  10  Horizontal sync pulse length, in clocks.
REQ-005 BackPorch  input  10  Back porch length, in clocks.
REQ-006 ActiveVideo  input  10  Active video length, in clocks.
REQ-007 FrontPorch  input  10  Front porch length, in clocks.
REQ-008 hsync  output  1  Horizontal sync; low during the sync phase, high otherwise.
REQ-009 LineEnd  output  1  One-clock high pulse on the last clock of each line; drives the vertical sync stage.
REQ-010 xposition  output  10  Pixel column during active video; 0 at all other times.
REQ-011 ActiveX  output  1  High only during the active video phase.

Function
REQ-012 The block SHALL implement a four-state machine with states SYNC, BACK, ACTIVE and FRONT, visited in that order and wrapping from FRONT back to SYNC.
REQ-013 A 10-bit phase counter SHALL start at 0 on entry to each state and increment every clock.
REQ-014 The machine SHALL leave a state on the clock where counter = (effective length − 1), and the counter SHALL clear to 0 on that transition.
REQ-015 Effective length of each phase SHALL be its shadow value, with a shadow value of 0 treated as 1; no phase is ever skipped.
REQ-016 The four length inputs SHALL be copied into shadow registers while reset is high and on the FRONT→SYNC transition; mid-line input changes take effect from the next line only.
REQ-017 Line period SHALL be the sum of the four effective lengths, in clocks.
REQ-018 All outputs SHALL be decoded from the current state and counter, with zero latency relative to the state.
- hsync = 0 iff state = SYNC.
- ActiveX = 1 iff state = ACTIVE.
- xposition = counter when ActiveX = 1, else 0.
- LineEnd = 1 iff state = FRONT and counter = effective FrontPorch − 1.
REQ-019 Arithmetic SHALL be 10-bit unsigned with no counter wrap; lengths up to 1023 SHALL be supported.
REQ-020 When all lengths are 1, the line SHALL be 4 clocks, with LineEnd asserted every 4th clock and xposition always 0.

Reset
REQ-021 Asserting reset SHALL immediately force:
- state = SYNC, counter = 0;
- hsync = 0, LineEnd = 0, ActiveX = 0, xposition = 0.
REQ-022 After reset deasserts, the first rising edge (cycle 0) SHALL be SYNC counter 0, using the length values present during reset.
REQ-023 Reset asserted mid-line SHALL abort the line without producing a LineEnd pulse; timing restarts from cycle 0 after release.

Verification
REQ-024 S=2, B=3, A=5, F=2, reset released → per 12-clock line:
- hsync=0 in cycles 0–1;
- ActiveX=1 in cycles 5–9 with xposition 0,1,2,3,4;
- LineEnd=1 only in cycle 11;
- cycle 12 is SYNC again.
REQ-025 Same lengths, 300 clocks → LineEnd period exactly 12 clocks, each pulse exactly 1 clock wide, no glitches.
REQ-026 Change ActiveVideo from 5 to 3 in cycle 6 → current line stays 12 clocks; next line is 10 clocks with xposition 0..2.
REQ-027 All lengths 0 → 4-clock line:
- hsync low in 1 of every 4 clocks;
- ActiveX high in 1 of every 4 clocks;
- LineEnd high in 1 of every 4 clocks.
REQ-028 Reset asserted asynchronously in cycle 7 (ACTIVE) → outputs reach reset values before the next edge; no LineEnd pulse; restart at SYNC cycle 0 after release.
REQ-029 S=96, B=48, A=640, F=16 → 800-clock line; xposition reaches 639 then returns to 0; LineEnd in clock 799.
